bit_recovery: RTL and testbench

Recovers the slow serial line `din` into a clean, clock-aligned bit stream for the 63-bit sync/packet detector, which consumes it directly upstream of the SPI slave. It synchronises the raw asynchronous line and realigns a bit-period counter on every transition. For each bit it emits a majority-voted `dout` together with a one-cycle `sh_en` strobe, replacing the free-running shift-enable timer. A lock indicator reports phase stability to the packet logic and SPI status.

---
 rtl/bit_recovery_pkg.sv | 12 +
 rtl/sync_2ff.sv | 24 ++
 rtl/bit_recovery.sv | 132 +++++++++++++
 tb/tb_bit_recovery.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bit_recovery_pkg.sv
// bit_recovery_pkg: shared types, default parameters and helpers for bit_recovery.
// Contents: state_t FSM encoding, DEF_* parameter defaults, maj3 voter.
package bit_recovery_pkg;
    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;
    localparam int DEF_CLK_PER_BIT = 10000;
    localparam int DEF_TOL = 200;
    localparam int DEF_LOCK_EDGES = 4;
    localparam int DEF_MAX_RUN = 16;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for asynchronous inputs.
// Ports: clk, rst (async active-high, flops reset to 0), d (async in), q (synchronised out).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d, s2_q, s2_d;
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/bit_recovery.sv
// bit_recovery: edge-realigned bit clock recovery with majority-voted sampling and lock detect.
// Ports: clk, rst (async active-high), en (low forces IDLE), din (raw async line),
//        dout (recovered bit), sh_en (one-cycle strobe per bit), lock (phase locked).
module bit_recovery
    import bit_recovery_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_EDGES  = DEF_LOCK_EDGES,
    parameter int MAX_RUN     = DEF_MAX_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic sh_en,
    output logic lock
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int GW = $clog2(LOCK_EDGES + 1);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] LAST      = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] MID_LO    = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID       = CW'(CLK_PER_BIT / 2);
    localparam logic [CW-1:0] MID_HI    = CW'(CLK_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LATE      = CW'(CLK_PER_BIT - TOL);
    localparam logic [CW-1:0] EARLY     = CW'(TOL);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_EDGES - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(MAX_RUN - 1);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [RW-1:0] run_q, run_d;
    logic din_s, din_dly_q, din_dly_d;
    logic smp_lo_q, smp_lo_d, smp_mid_q, smp_mid_d;
    logic dout_q, dout_d, sh_en_q, sh_en_d;
    logic active, edge_det, wrap, good_edge, timeout, sample;

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(din), .q(din_s));

    always_comb begin
        active    = en && state_q != IDLE;
        edge_det  = din_s ^ din_dly_q;
        wrap      = active && !edge_det && cnt_q == LAST;
        good_edge = cnt_q >= LATE || cnt_q <= EARLY;
        timeout   = wrap && run_q == RUN_LAST;
        // An edge in the sampling window kills the bit: cnt never reaches MID_HI, or the edge gates it here.
        sample    = active && !edge_det && cnt_q == MID_HI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (!en) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (edge_det) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
                TRACK: if (edge_det) begin
                    good_d = good_edge ? good_q + 1'b1 : '0;
                    if (good_edge && good_q == GOOD_LAST) begin
                        state_d = LOCK;
                        good_d  = '0;
                    end
                end
                LOCK: if ((edge_det && !good_edge) || timeout) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        lock = state_q == LOCK;
    end

    always_comb begin
        din_dly_d = din_s;
        // Edge wins over wrap; IDLE and disable hold the phase at zero.
        cnt_d     = (!active || edge_det || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        run_d     = (!active || edge_det) ? '0 : (wrap && run_q != RUN_MAX) ? run_q + 1'b1 : run_q;
        smp_lo_d  = (active && cnt_q == MID_LO) ? din_s : smp_lo_q;
        smp_mid_d = (active && cnt_q == MID) ? din_s : smp_mid_q;
        sh_en_d   = sample;
        dout_d    = !en ? 1'b0 : sample ? maj3(smp_lo_q, smp_mid_q, din_s) : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            run_q     <= '0;
            din_dly_q <= 1'b0;
            smp_lo_q  <= 1'b0;
            smp_mid_q <= 1'b0;
            sh_en_q   <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            din_dly_q <= din_dly_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
            sh_en_q   <= sh_en_d;
            dout_q    <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign sh_en = sh_en_q;
endmodule

// File: tb/tb_bit_recovery.sv
// tb_bit_recovery: directed table-driven bench for bit_recovery at 16 clocks per bit.
module tb_bit_recovery;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic din = 1'b0;
    logic dout, sh_en, lock;
    logic prev_sh = 1'b0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic v;
        int   len;
        logic exp_dout;
        logic exp_lock;
    } vec_t;
    vec_t vecs[$];

    bit_recovery #(.CLK_PER_BIT(16), .TOL(2), .LOCK_EDGES(4), .MAX_RUN(16)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .sh_en(sh_en), .lock(lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int len, input logic l);
        vecs.push_back('{v, len, v, l});
    endtask

    // Each bit window starts at a negedge with din set; the strobe lands 13 posedges later.
    task automatic run_vecs(input int lo, input int hi);
        for (int n = lo; n < hi; n++) begin
            int ns;
            int off;
            logic dv;
            din = vecs[n].v;
            ns = 0;
            off = -1;
            dv = 1'b0;
            for (int i = 1; i <= vecs[n].len; i++) begin
                @(negedge clk);
                if (sh_en) begin
                    ns++;
                    off = i;
                    dv = dout;
                end
            end
            check($sformatf("v%0d strobes", n), ns, 1);
            check($sformatf("v%0d offset", n), off, 13);
            check($sformatf("v%0d dout", n), int'(dv), int'(vecs[n].exp_dout));
            check($sformatf("v%0d lock", n), int'(lock), int'(vecs[n].exp_lock));
        end
    endtask

    task automatic wait_strobe(input string name, input int exp_off, input logic exp_d);
        int off;
        logic dv;
        off = -1;
        dv = 1'b0;
        for (int i = 1; i <= 40 && off < 0; i++) begin
            @(negedge clk);
            if (sh_en) begin
                off = i;
                dv = dout;
            end
        end
        check({name, " offset"}, off, exp_off);
        check({name, " dout"}, int'(dv), int'(exp_d));
    endtask

    task automatic quiet(input string name, input int n);
        int ns;
        ns = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sh_en) ns++;
        end
        check({name, " strobes"}, ns, 0);
    endtask

    always @(negedge clk) begin
        if (sh_en) check("sh_en back-to-back", int'(prev_sh), 0);
        prev_sh <= sh_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ig;
        int ir;
        int viol;
        for (int i = 0; i < 6; i++) add(i % 2 == 0, 16, i >= 4);
        for (int i = 0; i < 9; i++) add(1'b1, 16, 1'b1);
        add(1'b0, 16, 1'b1);
        for (int i = 1; i <= 17; i++) add(1'b0, 16, i <= 15);
        for (int i = 0; i < 20; i++) add(i % 2 == 0, 17, i >= 3);
        for (int i = 0; i < 6; i++) add(i % 2 == 0, 20, i == 0);
        for (int i = 0; i < 6; i++) add(i % 2 == 0, 16, i >= 4);
        ig = vecs.size();
        for (int i = 0; i < 5; i++) add(i % 2 == 0, 16, i >= 2);
        ir = vecs.size();
        for (int i = 0; i < 6; i++) add(i % 2 == 1, 16, i >= 3);

        repeat (3) @(negedge clk);
        check("reset dout", int'(dout), 0);
        check("reset sh_en", int'(sh_en), 0);
        check("reset lock", int'(lock), 0);
        rst = 1'b0;
        quiet("idle", 4);

        run_vecs(0, ig);

        repeat (6) @(negedge clk);
        check("glitch pre lock", int'(lock), 1);
        din = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch lock drop", int'(lock), 0);
        din = 1'b0;
        wait_strobe("glitch", 13, 1'b0);
        repeat (3) @(negedge clk);

        run_vecs(ig, ir);

        repeat (11) @(negedge clk);
        check("pre-reset lock", int'(lock), 1);
        check("pre-reset dout", int'(dout), 1);
        rst = 1'b1;
        din = 1'b0;
        #1;
        check("mid-bit reset dout", int'(dout), 0);
        check("mid-bit reset sh_en", int'(sh_en), 0);
        check("mid-bit reset lock", int'(lock), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet("post-reset idle", 40);
        check("post-reset lock", int'(lock), 0);
        din = 1'b1;
        wait_strobe("post-reset", 13, 1'b1);
        check("post-reset track lock", int'(lock), 0);
        repeat (3) @(negedge clk);

        run_vecs(ir, vecs.size());

        repeat (5) @(negedge clk);
        check("pre-disable lock", int'(lock), 1);
        check("pre-disable dout", int'(dout), 1);
        en = 1'b0;
        din = 1'b0;
        @(negedge clk);
        check("disable lock", int'(lock), 0);
        check("disable dout", int'(dout), 0);
        viol = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (sh_en || lock || dout) viol++;
            if (i == 16) din = 1'b1;
            if (i == 32) din = 1'b0;
        end
        check("disabled outputs high", viol, 0);
        en = 1'b1;
        quiet("re-enable idle", 10);
        din = 1'b1;
        wait_strobe("re-enable", 13, 1'b1);
        check("re-enable lock", int'(lock), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
